spi_mux_master: RTL and testbench

SPI_MUX_MASTER -- requirements
Module: spi_mux_master

---
 rtl/spi_mux_master.sv | 210 +++++++++++++++++++++
 tb/tb_spi_mux_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mux_master.sv
// spi_mux_master: mode-0 SPI master shared by NCH requesting channels.
// Channels are granted round-robin from IDLE. A granted channel owns the bus,
// with its select held low, until a word flagged Last has been shifted out.
module spi_mux_master #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8,
    parameter int DIVW  = 4
) (
    input  logic                 Clk,
    input  logic                 nReset,
    input  logic [NCH-1:0]       Req,
    input  logic [NCH-1:0]       Last,
    input  logic [NCH*WIDTH-1:0] TxData,
    input  logic [DIVW-1:0]      Div,
    output logic [NCH-1:0]       Ack,
    output logic [NCH-1:0]       RxValid,
    output logic [WIDTH-1:0]     RxData,
    output logic                 Busy,
    output logic                 SPIClk,
    output logic                 SPIDo,
    input  logic                 SPIDi,
    output logic [NCH-1:0]       SPISel
);

    localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, RELEASE} state_e;

    state_e            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic              last_q, last_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [DIVW-1:0]   divcnt_q, divcnt_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;

    logic [NCH-1:0]    ack_q, ack_d;
    logic [NCH-1:0]    rxvalid_q, rxvalid_d;
    logic [WIDTH-1:0]  rxdata_q, rxdata_d;
    logic              busy_q, busy_d;
    logic              spiclk_q, spiclk_d;
    logic              spido_q, spido_d;
    logic [NCH-1:0]    spisel_q, spisel_d;

    logic              found, load, done;
    logic [OW-1:0]     pick, cidx, load_ch;
    int unsigned       cand;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            sh_q      <= '0;
            rx_q      <= '0;
            last_q    <= 1'b0;
            div_q     <= '0;
            divcnt_q  <= '0;
            bitcnt_q  <= '0;
            ack_q     <= '0;
            rxvalid_q <= '0;
            rxdata_q  <= '0;
            busy_q    <= 1'b0;
            spiclk_q  <= 1'b0;
            spido_q   <= 1'b0;
            spisel_q  <= '1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            last_q    <= last_d;
            div_q     <= div_d;
            divcnt_q  <= divcnt_d;
            bitcnt_q  <= bitcnt_d;
            ack_q     <= ack_d;
            rxvalid_q <= rxvalid_d;
            rxdata_q  <= rxdata_d;
            busy_q    <= busy_d;
            spiclk_q  <= spiclk_d;
            spido_q   <= spido_d;
            spisel_q  <= spisel_d;
        end
    end

    // Next-state logic: arbitration, bit timing, shifting and word loading
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        last_d   = last_q;
        div_d    = div_q;
        divcnt_d = divcnt_q;
        bitcnt_d = bitcnt_q;
        load     = 1'b0;
        load_ch  = owner_q;
        done     = 1'b0;
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cidx     = '0;

        // first requester at or after the round-robin pointer
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = (32'(ptr_q) + k) % 32'(NCH);
            cidx = OW'(cand);
            if (!found && Req[cidx]) begin
                found = 1'b1;
                pick  = cidx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SETUP;
                    owner_d = pick;
                    ptr_d   = (int'(pick) == NCH - 1) ? '0 : pick + 1'b1;
                    div_d   = Div;
                    load    = 1'b1;
                    load_ch = pick;
                end
            end
            SETUP, LOW: begin
                if (divcnt_q == div_q) begin
                    divcnt_d = '0;
                    state_d  = HIGH;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (divcnt_q == '0) begin
                    rx_d    = rx_q << 1;
                    rx_d[0] = SPIDi;
                end
                if (divcnt_q == div_q) begin
                    divcnt_d = '0;
                    if (bitcnt_q == BW'(WIDTH - 1)) begin
                        done = 1'b1;
                        if (last_q) begin
                            state_d = RELEASE;
                        end else if (Req[owner_q]) begin
                            state_d = LOW;
                            load    = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        sh_d     = sh_q << 1;
                        state_d  = LOW;
                    end
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (Req[owner_q]) begin
                    state_d = LOW;
                    load    = 1'b1;
                end
            end
            RELEASE: begin
                if (divcnt_q == div_q) begin
                    divcnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Div is only captured at grant; a reload within a burst keeps it
        if (load) begin
            sh_d     = TxData[int'(load_ch)*WIDTH +: WIDTH];
            last_d   = Last[load_ch];
            bitcnt_d = '0;
            divcnt_d = '0;
        end
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        busy_d    = (state_d != IDLE);
        spiclk_d  = (state_d == HIGH);
        spido_d   = busy_d ? sh_d[WIDTH-1] : 1'b0;
        spisel_d  = busy_d ? ~(NCH'(1) << owner_d) : '1;
        ack_d     = load ? (NCH'(1) << owner_d) : '0;
        rxvalid_d = done ? (NCH'(1) << owner_q) : '0;
        rxdata_d  = done ? rx_d : rxdata_q;
    end

    assign Ack     = ack_q;
    assign RxValid = rxvalid_q;
    assign RxData  = rxdata_q;
    assign Busy    = busy_q;
    assign SPIClk  = spiclk_q;
    assign SPIDo   = spido_q;
    assign SPISel  = spisel_q;

endmodule

// File: tb/tb_spi_mux_master.sv
// tb_spi_mux_master: directed checks of spi_mux_master with SPIDi looped back to SPIDo.
module tb_spi_mux_master;

    localparam int NCH   = 2;
    localparam int WIDTH = 8;
    localparam int DIVW  = 4;

    logic                 Clk;
    logic                 nReset;
    logic [NCH-1:0]       Req;
    logic [NCH-1:0]       Last;
    logic [NCH*WIDTH-1:0] TxData;
    logic [DIVW-1:0]      Div;
    logic [NCH-1:0]       Ack;
    logic [NCH-1:0]       RxValid;
    logic [WIDTH-1:0]     RxData;
    logic                 Busy;
    logic                 SPIClk;
    logic                 SPIDo;
    logic                 SPIDi;
    logic [NCH-1:0]       SPISel;

    int n_cmp = 0;
    int n_err = 0;

    spi_mux_master #(.NCH(NCH), .WIDTH(WIDTH), .DIVW(DIVW)) dut (
        .Clk(Clk), .nReset(nReset), .Req(Req), .Last(Last), .TxData(TxData),
        .Div(Div), .Ack(Ack), .RxValid(RxValid), .RxData(RxData), .Busy(Busy),
        .SPIClk(SPIClk), .SPIDo(SPIDo), .SPIDi(SPIDi), .SPISel(SPISel)
    );

    assign SPIDi = SPIDo;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Bus monitor, sampled on the falling edge
    logic             mon_clr = 1'b0;
    logic             prev_sclk = 1'b0;
    logic [31:0]      bits_acc;
    int               nbits, hi_len, hi_min, hi_max, nhi;
    int               busy_cnt, sel_low_cnt, nack, nrx;
    int               sel_viol = 0;
    logic [WIDTH-1:0] rx_data_log [8];
    logic [NCH-1:0]   rx_ch_log [8];

    always @(negedge Clk) begin
        if (mon_clr) begin
            bits_acc    <= '0;
            nbits       <= 0;
            hi_len      <= 0;
            hi_min      <= 1000;
            hi_max      <= 0;
            nhi         <= 0;
            busy_cnt    <= 0;
            sel_low_cnt <= 0;
            nack        <= 0;
            nrx         <= 0;
        end else begin
            if (SPIClk === 1'b1 && prev_sclk !== 1'b1) begin
                bits_acc <= {bits_acc[30:0], SPIDo};
                nbits    <= nbits + 1;
                hi_len   <= 1;
            end else if (SPIClk === 1'b1) begin
                hi_len <= hi_len + 1;
            end
            if (SPIClk !== 1'b1 && prev_sclk === 1'b1) begin
                nhi <= nhi + 1;
                if (hi_len < hi_min) hi_min <= hi_len;
                if (hi_len > hi_max) hi_max <= hi_len;
            end
            if (Busy === 1'b1) busy_cnt <= busy_cnt + 1;
            if (SPISel !== '1) sel_low_cnt <= sel_low_cnt + 1;
            if (Ack !== '0) nack <= nack + 1;
            if (RxValid !== '0) begin
                if (nrx < 8) begin
                    rx_data_log[nrx] <= RxData;
                    rx_ch_log[nrx]   <= RxValid;
                end
                nrx <= nrx + 1;
            end
        end
        if ($countones(~SPISel) > 1) sel_viol <= sel_viol + 1;
        prev_sclk <= SPIClk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge Clk);
        #1;
        mon_clr = 1'b0;
        tick(1);
    endtask

    task automatic wait_ack(output logic [NCH-1:0] a, output int c);
        a = '0;
        c = 0;
        while (a == '0 && c < 300) begin
            tick(1);
            c++;
            a = Ack;
        end
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (Busy !== 1'b0 && c < 500) begin
            tick(1);
            c++;
        end
        check_eq(tag, Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NCH-1:0] a;
        int c;
        logic [NCH-1:0] exp_grant [4];

        // ---- reset state
        nReset = 1'b0; Req = '0; Last = '0; TxData = '0; Div = '0;
        tick(3);
        check_eq("rst_sel", SPISel, 2'b11);
        check_eq("rst_sclk", SPIClk, 0);
        check_eq("rst_sdo", SPIDo, 0);
        check_eq("rst_ack", Ack, 0);
        check_eq("rst_rxv", RxValid, 0);
        check_eq("rst_rxd", RxData, 0);
        check_eq("rst_busy", Busy, 0);
        nReset = 1'b1;
        tick(1);

        // ---- single word, Div=0
        mon_clear();
        Div = 4'd0; TxData[7:0] = 8'hA5; Last = 2'b01; Req = 2'b01;
        wait_ack(a, c);
        check_eq("w1_ack", a, 2'b01);
        check_eq("w1_ack_lat", c, 1);
        check_eq("w1_sel", SPISel, 2'b10);
        check_eq("w1_busy", Busy, 1);
        check_eq("w1_sdo_msb", SPIDo, 1);
        check_eq("w1_sclk", SPIClk, 0);
        Req = 2'b00;
        wait_idle("w1_idle");
        check_eq("w1_nbits", nbits, 8);
        check_eq("w1_bits", bits_acc[7:0], 8'hA5);
        check_eq("w1_nhi", nhi, 8);
        check_eq("w1_himin", hi_min, 1);
        check_eq("w1_himax", hi_max, 1);
        check_eq("w1_nrx", nrx, 1);
        check_eq("w1_rxch", rx_ch_log[0], 2'b01);
        check_eq("w1_rxd", rx_data_log[0], 8'hA5);
        check_eq("w1_busycnt", busy_cnt, 17);
        check_eq("w1_sel_end", SPISel, 2'b11);
        check_eq("w1_rxdata", RxData, 8'hA5);

        // ---- arbitration from reset, both requesting continuously
        nReset = 1'b0;
        tick(2);
        nReset = 1'b1;
        tick(1);
        mon_clear();
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
        TxData = {8'hC3, 8'h3C}; Last = 2'b11; Div = 4'd0; Req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(a, c);
            check_eq("arb_grant", a, exp_grant[i]);
            check_eq("arb_gap", c, (i == 0) ? 1 : 18);
            if (i == 3) Req = 2'b00;
        end
        wait_idle("arb_idle");
        check_eq("arb_nrx", nrx, 4);
        check_eq("arb_rx0", {rx_ch_log[0], rx_data_log[0]}, {2'b01, 8'h3C});
        check_eq("arb_rx1", {rx_ch_log[1], rx_data_log[1]}, {2'b10, 8'hC3});
        check_eq("arb_rx2", {rx_ch_log[2], rx_data_log[2]}, {2'b01, 8'h3C});
        check_eq("arb_rx3", {rx_ch_log[3], rx_data_log[3]}, {2'b10, 8'hC3});

        // ---- back-to-back burst on ch1, Div=2
        mon_clear();
        Div = 4'd2; TxData[15:8] = 8'h12; Last = 2'b00; Req = 2'b10;
        wait_ack(a, c);
        check_eq("bst_ack1", a, 2'b10);
        TxData[15:8] = 8'h34; Last = 2'b10;
        wait_ack(a, c);
        check_eq("bst_ack2", a, 2'b10);
        check_eq("bst_ack2_lat", c, 48);
        Req = 2'b00;
        wait_idle("bst_idle");
        check_eq("bst_nbits", nbits, 16);
        check_eq("bst_bits", bits_acc[15:0], 16'h1234);
        check_eq("bst_himin", hi_min, 3);
        check_eq("bst_himax", hi_max, 3);
        check_eq("bst_nrx", nrx, 2);
        check_eq("bst_rx0", {rx_ch_log[0], rx_data_log[0]}, {2'b10, 8'h12});
        check_eq("bst_rx1", {rx_ch_log[1], rx_data_log[1]}, {2'b10, 8'h34});
        check_eq("bst_busycnt", busy_cnt, 99);
        check_eq("bst_sellow", sel_low_cnt, 99);
        check_eq("bst_nack", nack, 2);

        // ---- hold: ch0 drops Req mid-burst while ch1 waits
        mon_clear();
        Div = 4'd0; TxData = {8'h81, 8'h5A}; Last = 2'b10; Req = 2'b11;
        wait_ack(a, c);
        check_eq("hld_ack0", a, 2'b01);
        Req = 2'b10;
        tick(36);
        check_eq("hld_busy", Busy, 1);
        check_eq("hld_sel", SPISel, 2'b10);
        check_eq("hld_sclk", SPIClk, 0);
        check_eq("hld_nack", nack, 1);
        check_eq("hld_nrx", nrx, 1);
        check_eq("hld_rx0", rx_data_log[0], 8'h5A);
        TxData[7:0] = 8'hE7; Last = 2'b11; Req = 2'b11;
        wait_ack(a, c);
        check_eq("hld_resume", a, 2'b01);
        check_eq("hld_resume_lat", c, 1);
        Req = 2'b10;
        wait_ack(a, c);
        check_eq("hld_ch1", a, 2'b10);
        check_eq("hld_ch1_lat", c, 18);
        Req = 2'b00;
        wait_idle("hld_idle");
        check_eq("hld_nrx_end", nrx, 3);
        check_eq("hld_rx1", {rx_ch_log[1], rx_data_log[1]}, {2'b01, 8'hE7});
        check_eq("hld_rx2", {rx_ch_log[2], rx_data_log[2]}, {2'b10, 8'h81});

        // ---- Div changed mid-burst is ignored until next grant
        mon_clear();
        Div = 4'd1; TxData[7:0] = 8'hF0; Last = 2'b00; Req = 2'b01;
        wait_ack(a, c);
        check_eq("div_ack1", a, 2'b01);
        Div = 4'd7; TxData[7:0] = 8'h0F; Last = 2'b01;
        wait_ack(a, c);
        check_eq("div_ack2", a, 2'b01);
        check_eq("div_ack2_lat", c, 32);
        Req = 2'b00;
        wait_idle("div_idle");
        check_eq("div_himin", hi_min, 2);
        check_eq("div_himax", hi_max, 2);
        check_eq("div_nhi", nhi, 16);
        check_eq("div_bits", bits_acc[15:0], 16'hF00F);
        check_eq("div_busycnt", busy_cnt, 66);

        // ---- reset in the middle of a word
        mon_clear();
        Div = 4'd0; TxData[7:0] = 8'hFF; Last = 2'b01; Req = 2'b01;
        wait_ack(a, c);
        check_eq("mrst_ack", a, 2'b01);
        Req = 2'b00;
        tick(6);
        check_eq("mrst_nbits", nbits, 3);
        nReset = 1'b0;
        tick(1);
        check_eq("mrst_sel", SPISel, 2'b11);
        check_eq("mrst_sclk", SPIClk, 0);
        check_eq("mrst_busy", Busy, 0);
        check_eq("mrst_sdo", SPIDo, 0);
        check_eq("mrst_ack0", Ack, 0);
        check_eq("mrst_rxv", RxValid, 0);
        nReset = 1'b1;
        tick(20);
        check_eq("mrst_nrx", nrx, 0);
        check_eq("mrst_rxd", RxData, 0);
        check_eq("mrst_idle", Busy, 0);

        check_eq("sel_onehot", sel_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
